blink_rate_ctrl: RTL and testbench

LED blink generator stepped by button presses. Sits directly downstream of the button debouncer: each debounced rising-edge pulse advances the blink rate through `NUM_RATES` speed settings, and the block drives the board LED with a square wave at the selected rate. Also exports the current rate index and a wrap pulse for status LEDs or other consumers.

---
 rtl/blink_rate_ctrl.sv | 136 +++++++++++++
 tb/tb_blink_rate_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/blink_rate_ctrl.sv
// blink_rate_ctrl: LED square-wave generator whose rate is stepped by
// single-cycle pulses from the button debouncer. Each step halves the
// half-period; stepping past the last rate wraps and pulses `wrap`.
// Optional feature macro: BLINK_OFF_EN (adds an OFF state entered on reset
// and on wrap, in which the LED stays dark until the next step).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_OFF   | LED dark, rate 0, counter parked at 0 (BLINK_OFF_EN only)
// ST_BLINK | LED toggles every HP(rate) cycles; step restarts the phase
module blink_rate_ctrl #(
  parameter int BASE_HALF_PERIOD = 25_000_000,
  parameter int NUM_RATES        = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         step,
  output logic                         led,
  output logic [$clog2(NUM_RATES)-1:0] rate,
  output logic                         wrap
);

  localparam int RATE_W = $clog2(NUM_RATES);
  localparam int CNT_W  = $clog2(BASE_HALF_PERIOD + 1);

  localparam logic [CNT_W-1:0]  BASE_C    = CNT_W'(BASE_HALF_PERIOD);
  localparam logic [RATE_W-1:0] LAST_RATE = RATE_W'(NUM_RATES - 1);

`ifdef BLINK_OFF_EN
  typedef enum logic [0:0] {
    ST_OFF   = 1'b0,
    ST_BLINK = 1'b1
  } state_t;
  localparam state_t RESET_STATE = ST_OFF;
`else
  typedef enum logic [0:0] {
    ST_BLINK = 1'b0
  } state_t;
  localparam state_t RESET_STATE = ST_BLINK;
`endif

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_led;
  logic [RATE_W-1:0]  r_rate;
  logic               r_wrap;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_led_nxt;
  logic [RATE_W-1:0]  w_rate_nxt;
  logic               w_wrap_nxt;

  logic [CNT_W-1:0]   w_hp;
  logic [CNT_W-1:0]   w_hp_m1;
  logic               w_tc;

  // Terminal count for the current rate: half-period shrinks by 2x per index.
  always_comb begin
    w_hp    = BASE_C >> r_rate;
    w_hp_m1 = w_hp - CNT_W'(1);
    w_tc    = (r_cnt == w_hp_m1);
  end

  // Next-state and next-output logic; step wins over terminal count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_led_nxt   = r_led;
    w_rate_nxt  = r_rate;
    w_wrap_nxt  = 1'b0;

    case (r_state)
`ifdef BLINK_OFF_EN
      ST_OFF: begin
        w_cnt_nxt  = '0;
        w_led_nxt  = 1'b0;
        w_rate_nxt = '0;
        if (step) begin
          w_state_nxt = ST_BLINK;
          w_led_nxt   = 1'b1;
        end
      end
`endif
      ST_BLINK: begin
        if (step) begin
          w_cnt_nxt = '0;
          w_led_nxt = 1'b1;
          if (r_rate == LAST_RATE) begin
            w_rate_nxt = '0;
            w_wrap_nxt = 1'b1;
`ifdef BLINK_OFF_EN
            w_state_nxt = ST_OFF;
            w_led_nxt   = 1'b0;
`endif
          end else begin
            w_rate_nxt = r_rate + RATE_W'(1);
          end
        end else if (w_tc) begin
          w_cnt_nxt = '0;
          w_led_nxt = ~r_led;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = RESET_STATE;
        w_cnt_nxt   = '0;
        w_led_nxt   = 1'b0;
        w_rate_nxt  = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything without a clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RESET_STATE;
      r_cnt   <= '0;
      r_led   <= 1'b0;
      r_rate  <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_led   <= w_led_nxt;
      r_rate  <= w_rate_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign led  = r_led;
  assign rate = r_rate;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Testbench for blink_rate_ctrl with BASE_HALF_PERIOD=8, NUM_RATES=4
// (half-periods 8,4,2,1). A phase-based model predicts led/rate/wrap every
// cycle; directed literal checks pin key points of the model.
module tb_blink_rate_ctrl;

  localparam int BASE = 8;
  localparam int NR   = 4;
`ifdef BLINK_OFF_EN
  localparam bit OFF_EN = 1'b1;
`else
  localparam bit OFF_EN = 1'b0;
`endif

  logic       clock;
  logic       reset_n;
  logic       step;
  logic       led;
  logic [1:0] rate;
  logic       wrap;

  int n_checks = 0;
  int n_pass   = 0;

  blink_rate_ctrl #(
    .BASE_HALF_PERIOD(BASE),
    .NUM_RATES       (NR)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .step   (step),
    .led    (led),
    .rate   (rate),
    .wrap   (wrap)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model: blinking flag, rate index, cycles since phase restart, start level.
  bit m_on    = !OFF_EN;
  int m_rate  = 0;
  int m_t     = 0;
  bit m_start = 1'b0;
  bit m_wrap  = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_on    = !OFF_EN;
      m_rate  = 0;
      m_t     = 0;
      m_start = 1'b0;
      m_wrap  = 1'b0;
    end else if (step) begin
      m_wrap = m_on && (m_rate == NR - 1);
      if (!m_on) begin
        m_on   = 1'b1;
        m_rate = 0;
      end else if (m_rate == NR - 1) begin
        m_rate = 0;
        if (OFF_EN) m_on = 1'b0;
      end else begin
        m_rate = m_rate + 1;
      end
      m_t     = 0;
      m_start = 1'b1;
    end else begin
      m_wrap = 1'b0;
      if (m_on) m_t = m_t + 1;
    end
  end

  function automatic int exp_led();
    int hp;
    hp = BASE >> m_rate;
    if (!m_on) return 0;
    return int'(m_start) ^ ((m_t / hp) % 2);
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, expv);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    check("cmp_led",  int'(led),  exp_led());
    check("cmp_rate", int'(rate), m_rate);
    check("cmp_wrap", int'(wrap), int'(m_wrap));
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse();
    step = 1'b1;
    edges(1);
    step = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    step    = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;

`ifdef BLINK_OFF_EN
    edges(20);
    check("off_led_dark", int'(led), 0);
    check("off_rate0", int'(rate), 0);
    pulse();
    check("off_wake_led", int'(led), 1);
    check("off_wake_rate", int'(rate), 0);
    check("off_wake_wrap", int'(wrap), 0);
    edges(10);
    pulse();
    check("off_r1", int'(rate), 1);
    edges(5);
    pulse();
    check("off_r2", int'(rate), 2);
    edges(5);
    pulse();
    check("off_r3", int'(rate), 3);
    check("off_r3_led", int'(led), 1);
    edges(3);
    pulse();
    check("off_wrap_rate", int'(rate), 0);
    check("off_wrap_led", int'(led), 0);
    check("off_wrap_pulse", int'(wrap), 1);
    edges(1);
    check("off_wrap_clear", int'(wrap), 0);
    edges(20);
    check("off_stay_dark", int'(led), 0);
`else
    // Free-running at rate 0 after reset.
    edges(7);
    check("rst_led_hold", int'(led), 0);
    check("rst_rate", int'(rate), 0);
    edges(1);
    check("first_toggle", int'(led), 1);
    edges(8);
    check("second_toggle", int'(led), 0);

    // Step through all rates.
    pulse();
    check("s1_rate", int'(rate), 1);
    check("s1_led", int'(led), 1);
    edges(3);
    check("s1_hold", int'(led), 1);
    edges(1);
    check("s1_toggle", int'(led), 0);
    edges(16);

    pulse();
    check("s2_rate", int'(rate), 2);
    check("s2_led", int'(led), 1);
    edges(1);
    check("s2_hold", int'(led), 1);
    edges(1);
    check("s2_toggle", int'(led), 0);
    edges(18);

    pulse();
    check("s3_rate", int'(rate), 3);
    check("s3_led", int'(led), 1);
    check("s3_nowrap", int'(wrap), 0);
    edges(1);
    check("s3_toggle1", int'(led), 0);
    edges(1);
    check("s3_toggle2", int'(led), 1);
    edges(18);

    pulse();
    check("s4_rate", int'(rate), 0);
    check("s4_led", int'(led), 1);
    check("s4_wrap", int'(wrap), 1);
    edges(1);
    check("s4_wrap_clear", int'(wrap), 0);
    edges(6);
    check("s4_hold7", int'(led), 1);

    // Step lands on the rate-0 terminal-count cycle: no toggle.
    pulse();
    check("tc_led", int'(led), 1);
    check("tc_rate", int'(rate), 1);
    check("tc_wrap", int'(wrap), 0);
    edges(3);
    check("tc_hold", int'(led), 1);
    edges(1);
    check("tc_toggle", int'(led), 0);

    // Asynchronous reset mid-period at rate 2.
    pulse();
    check("ar_rate_before", int'(rate), 2);
    edges(1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_led", int'(led), 0);
    check("ar_rate", int'(rate), 0);
    check("ar_wrap", int'(wrap), 0);
    edges(2);
    @(negedge clock) reset_n = 1'b1;
    edges(7);
    check("ar_post_hold", int'(led), 0);
    edges(1);
    check("ar_post_toggle", int'(led), 1);

    // Step held high for three cycles.
    step = 1'b1;
    edges(1);
    check("hold_r1", int'(rate), 1);
    check("hold_l1", int'(led), 1);
    edges(1);
    check("hold_r2", int'(rate), 2);
    check("hold_l2", int'(led), 1);
    edges(1);
    check("hold_r3", int'(rate), 3);
    check("hold_l3", int'(led), 1);
    step = 1'b0;
    check("hold_nowrap", int'(wrap), 0);
    edges(1);
    check("hold_hp1_toggle", int'(led), 0);
    edges(10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
